// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and oversampling constants for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] MID_SAMPLE  = TICK_W'(7);
    localparam logic [TICK_W-1:0] LAST_SAMPLE = TICK_W'(15);

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - N-stage input synchronizer with rising-edge pulse
module uart_rx_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the raw input down the chain and remember the last synced level
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // Chain registers, preset to the line's idle level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with holding register and error flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_16bd,
    input  logic                 rx,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int             BCW      = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
    localparam logic           ODD      = (PARITY_ODD != 0);

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  overrun_err_q, overrun_err_d;

    logic rx_s;
    logic tick;
    logic complete;
    logic rx_rise_unused;
    logic clk16_lvl_unused;

    uart_rx_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rx_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx),
        .dout (rx_s),
        .rise (rx_rise_unused)
    );

    uart_rx_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_tick_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (clk_16bd),
        .dout (clk16_lvl_unused),
        .rise (tick)
    );

    // State, counters, shift register and holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            perr_q        <= 1'b0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            perr_q        <= perr_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    // Frame sequencing; everything advances only on oversample ticks
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        complete   = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == MID_SAMPLE) begin
                        if (!rx_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == LAST_SAMPLE) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_cnt_q == BCW'(i)) begin
                                shreg_d[i] = rx_s;
                            end
                        end
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        tick_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_cnt_q == LAST_SAMPLE) begin
                        perr_d     = ((^shreg_q) ^ rx_s) != ODD;
                        tick_cnt_d = '0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == LAST_SAMPLE) begin
                        complete   = 1'b1;
                        tick_cnt_d = '0;
                        state_d    = rx_s ? IDLE : BREAK;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register load, overrun detection and consumer handshake
    always_comb begin
        data_d        = data_q;
        data_valid_d  = data_valid_q;
        frame_err_d   = frame_err_q;
        parity_err_d  = parity_err_q;
        overrun_err_d = overrun_err_q;
        busy          = (state_q != IDLE);
        if (complete) begin
            if (!data_valid_q || data_ack) begin
                data_d       = shreg_q;
                frame_err_d  = ~rx_s;
                parity_err_d = perr_q;
                data_valid_d = 1'b1;
                if (data_valid_q) begin
                    overrun_err_d = 1'b0;
                end
            end else begin
                overrun_err_d = 1'b1;
            end
        end else if (data_valid_q && data_ack) begin
            data_valid_d  = 1'b0;
            frame_err_d   = 1'b0;
            parity_err_d  = 1'b0;
            overrun_err_d = 1'b0;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] div = 3'd0;
    logic       clk_16bd;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       data_ack = 1'b0;
    logic       ack_p = 1'b0;

    logic [7:0] data, p_data;
    logic       data_valid, frame_err, parity_err, overrun_err, busy;
    logic       p_valid, p_frame_err, p_parity_err, p_overrun_err, p_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #2 clk = ~clk;
    always @(negedge clk) div <= div + 3'd1;
    assign clk_16bd = div[2];

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .clk_16bd(clk_16bd), .rx(rx), .data_ack(data_ack),
        .data(data), .data_valid(data_valid), .frame_err(frame_err),
        .parity_err(parity_err), .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_p (
        .clk(clk), .rst(rst), .clk_16bd(clk_16bd), .rx(rx_p), .data_ack(ack_p),
        .data(p_data), .data_valid(p_valid), .frame_err(p_frame_err),
        .parity_err(p_parity_err), .overrun_err(p_overrun_err), .busy(p_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * 8) @(negedge clk);
    endtask

    task automatic drive(input bit to_p, input logic v);
        if (to_p) rx_p = v;
        else rx = v;
    endtask

    // Returns at the oversample tick that lands mid stop bit
    task automatic send_frame(input bit to_p, input logic [7:0] d, input bit use_par,
                              input bit par, input bit stop_v);
        @(posedge clk_16bd);
        drive(to_p, 1'b0);
        ticks(16);
        for (int k = 0; k < 8; k++) begin
            drive(to_p, d[k]);
            ticks(16);
        end
        if (use_par) begin
            drive(to_p, par);
            ticks(16);
        end
        drive(to_p, stop_v);
        ticks(8);
    endtask

    task automatic expect_done(input bit to_p, input logic [7:0] d, input bit dv_pre,
                               input bit fe, input bit pe, input bit ov);
        @(negedge clk);
        @(negedge clk);
        chk("valid_before_complete", to_p ? p_valid : data_valid, dv_pre);
        @(negedge clk);
        chk("data", to_p ? p_data : data, d);
        chk("data_valid", to_p ? p_valid : data_valid, 1);
        chk("frame_err", to_p ? p_frame_err : frame_err, fe);
        chk("parity_err", to_p ? p_parity_err : parity_err, pe);
        chk("overrun_err", to_p ? p_overrun_err : overrun_err, ov);
    endtask

    task automatic ack_on_complete(input logic [7:0] d);
        @(negedge clk);
        @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        chk("ack_cmpl_data", data, d);
        chk("ack_cmpl_valid", data_valid, 1);
        chk("ack_cmpl_overrun", overrun_err, 0);
    endtask

    task automatic do_ack(input bit to_p);
        @(negedge clk);
        if (to_p) ack_p = 1'b1;
        else data_ack = 1'b1;
        @(negedge clk);
        ack_p = 1'b0;
        data_ack = 1'b0;
        chk("ack_valid", to_p ? p_valid : data_valid, 0);
        chk("ack_frame_err", to_p ? p_frame_err : frame_err, 0);
        chk("ack_parity_err", to_p ? p_parity_err : parity_err, 0);
        chk("ack_overrun", to_p ? p_overrun_err : overrun_err, 0);
    endtask

    initial begin
        logic [7:0] partial;
        partial = 8'hAB;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun_err, 0);
        rst = 1'b1;
        ticks(4);

        // basic receive
        send_frame(0, 8'hA5, 0, 0, 1);
        expect_done(0, 8'hA5, 0, 0, 0, 0);
        do_ack(0);
        ticks(8);

        // false start glitch
        @(posedge clk_16bd);
        rx = 1'b0;
        ticks(3);
        rx = 1'b1;
        chk("glitch_busy", busy, 1);
        ticks(8);
        chk("glitch_idle", busy, 0);
        chk("glitch_no_valid", data_valid, 0);
        send_frame(0, 8'h3C, 0, 0, 1);
        expect_done(0, 8'h3C, 0, 0, 0, 0);
        do_ack(0);
        ticks(8);

        // framing error followed by a long break
        send_frame(0, 8'h55, 0, 0, 0);
        expect_done(0, 8'h55, 0, 1, 0, 0);
        do_ack(0);
        @(posedge clk_16bd);
        ticks(30);
        chk("break_busy", busy, 1);
        ticks(1);
        rx = 1'b1;
        ticks(4);
        chk("break_released", busy, 0);
        ticks(200);
        chk("break_no_frame", data_valid, 0);

        // overrun, then acknowledge exactly on completion
        send_frame(0, 8'h11, 0, 0, 1);
        expect_done(0, 8'h11, 0, 0, 0, 0);
        ticks(8);
        send_frame(0, 8'h22, 0, 0, 1);
        expect_done(0, 8'h11, 1, 0, 0, 1);
        do_ack(0);
        ticks(8);
        send_frame(0, 8'h33, 0, 0, 1);
        ack_on_complete(8'h33);
        ticks(8);
        send_frame(0, 8'h66, 0, 0, 1);
        ack_on_complete(8'h66);
        do_ack(0);
        ticks(8);

        // even parity on the parity-enabled instance
        send_frame(1, 8'h07, 1, 1, 1);
        expect_done(1, 8'h07, 0, 0, 0, 0);
        do_ack(1);
        ticks(8);
        send_frame(1, 8'h07, 1, 0, 1);
        expect_done(1, 8'h07, 0, 0, 1, 0);
        do_ack(1);
        ticks(8);

        // reset in the middle of a frame
        send_frame(0, 8'h99, 0, 0, 1);
        expect_done(0, 8'h99, 0, 0, 0, 0);
        ticks(8);
        @(posedge clk_16bd);
        rx = 1'b0;
        ticks(16);
        for (int k = 0; k < 4; k++) begin
            rx = partial[k];
            ticks(16);
        end
        rx = partial[4];
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_valid", data_valid, 1);
        rst = 1'b0;
        rx = 1'b1;
        #1;
        chk("midrst_data", data, 0);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_busy", busy, 0);
        ticks(2);
        rst = 1'b1;
        ticks(4);
        send_frame(0, 8'hF0, 0, 0, 1);
        expect_done(0, 8'hF0, 0, 0, 0, 0);
        do_ack(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
